// File: rtl/busca_instrucao_pkg.sv
// Shared definitions for the instruction fetch unit.
//   estado_t      : fetch FSM state encoding
//   LARGURA_DADO  : instruction/data word width
//   LARGURA_END   : memory address width (8-word memory)
//   LARGURA_PC    : program counter width
package busca_instrucao_pkg;

  localparam int unsigned LARGURA_DADO = 16;
  localparam int unsigned LARGURA_END  = 3;
  localparam int unsigned LARGURA_PC   = 16;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    ENDERECA = 2'd1,
    LE       = 2'd2,
    ENTREGA  = 2'd3
  } estado_t;

endpackage

// File: rtl/busca_instrucao_contador_programa.sv
// Program counter register.
//   relogio_in    : clock, rising edge
//   reinicia_n_in : asynchronous active-low reset (PC -> 0)
//   carrega_in    : load PC from alvo_in (wins over incrementa_in)
//   incrementa_in : PC <= PC + 1, wrapping at the top of the range
//   alvo_in       : load value
//   pc_out        : current program counter
module contador_programa
  import busca_instrucao_pkg::*;
#(
  parameter int unsigned LARGURA = LARGURA_PC
) (
  input  logic               relogio_in,
  input  logic               reinicia_n_in,
  input  logic               carrega_in,
  input  logic               incrementa_in,
  input  logic [LARGURA-1:0] alvo_in,
  output logic [LARGURA-1:0] pc_out
);

  always_ff @(posedge relogio_in or negedge reinicia_n_in) begin
    if (!reinicia_n_in) begin
      pc_out <= '0;
    end else if (carrega_in) begin
      pc_out <= alvo_in;
    end else if (incrementa_in) begin
      pc_out <= pc_out + 1'b1;
    end
  end

endmodule

// File: rtl/busca_instrucao.sv
// Instruction fetch unit: reads one word per PC from a combinational-read
// memory and hands it to a consumer with a valid/ready handshake.
//   relogio_in    : clock, rising edge
//   reinicia_n_in : asynchronous active-low reset
//   inicia_in     : level request to keep fetching
//   salto_in      : load PC from alvo_in, discard any pending word
//   alvo_in       : jump target PC
//   endereco_out  : registered memory read address
//   ram_dado_in   : memory read data for endereco_out
//   instrucao_out : registered fetched word
//   valida_out    : instrucao_out valid for the consumer
//   aceita_in     : consumer ready
//   pc_out        : current program counter
//   ativo_out     : high whenever the FSM is not idle
module busca_instrucao
  import busca_instrucao_pkg::*;
#(
  parameter int unsigned LARGURA_DADO = busca_instrucao_pkg::LARGURA_DADO,
  parameter int unsigned LARGURA_END  = busca_instrucao_pkg::LARGURA_END
) (
  input  logic                    relogio_in,
  input  logic                    reinicia_n_in,
  input  logic                    inicia_in,
  input  logic                    salto_in,
  input  logic [LARGURA_PC-1:0]   alvo_in,
  output logic [LARGURA_END-1:0]  endereco_out,
  input  logic [LARGURA_DADO-1:0] ram_dado_in,
  output logic [LARGURA_DADO-1:0] instrucao_out,
  output logic                    valida_out,
  input  logic                    aceita_in,
  output logic [LARGURA_PC-1:0]   pc_out,
  output logic                    ativo_out
);

  estado_t estado;
  logic    incrementa;

  // A jump on the same edge as a transfer suppresses the increment.
  assign incrementa = (estado == ENTREGA) && aceita_in && !salto_in;
  assign ativo_out  = (estado != OCIOSO);

  contador_programa #(
    .LARGURA (LARGURA_PC)
  ) u_contador_programa (
    .relogio_in    (relogio_in),
    .reinicia_n_in (reinicia_n_in),
    .carrega_in    (salto_in),
    .incrementa_in (incrementa),
    .alvo_in       (alvo_in),
    .pc_out        (pc_out)
  );

  always_ff @(posedge relogio_in or negedge reinicia_n_in) begin
    if (!reinicia_n_in) begin
      estado        <= OCIOSO;
      endereco_out  <= '0;
      instrucao_out <= '0;
      valida_out    <= 1'b0;
    end else if (salto_in) begin
      // Jump discards the pending word; when idle only the PC moves.
      valida_out <= 1'b0;
      if (estado != OCIOSO) begin
        estado <= ENDERECA;
      end
    end else begin
      case (estado)
        OCIOSO: begin
          if (inicia_in) begin
            estado <= ENDERECA;
          end
        end
        ENDERECA: begin
          endereco_out <= pc_out[LARGURA_END-1:0];
          estado       <= inicia_in ? LE : OCIOSO;
        end
        LE: begin
          instrucao_out <= ram_dado_in;
          valida_out    <= 1'b1;
          estado        <= ENTREGA;
        end
        ENTREGA: begin
          if (aceita_in) begin
            valida_out <= 1'b0;
            estado     <= ENDERECA;
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_busca_instrucao.sv
// Directed self-checking bench for busca_instrucao with an 8-word
// combinational-read memory model.
module tb_busca_instrucao;

  logic        relogio;
  logic        reinicia_n;
  logic        inicia;
  logic        salto;
  logic [15:0] alvo;
  logic [2:0]  endereco;
  logic [15:0] ram_dado;
  logic [15:0] instrucao;
  logic        valida;
  logic        aceita;
  logic [15:0] pc;
  logic        ativo;

  logic [15:0] ram [8];

  int n_checks = 0;
  int n_pass   = 0;

  assign ram_dado = ram[endereco];

  busca_instrucao #(
    .LARGURA_DADO (16),
    .LARGURA_END  (3)
  ) dut (
    .relogio_in    (relogio),
    .reinicia_n_in (reinicia_n),
    .inicia_in     (inicia),
    .salto_in      (salto),
    .alvo_in       (alvo),
    .endereco_out  (endereco),
    .ram_dado_in   (ram_dado),
    .instrucao_out (instrucao),
    .valida_out    (valida),
    .aceita_in     (aceita),
    .pc_out        (pc),
    .ativo_out     (ativo)
  );

  initial relogio = 1'b0;
  always #5 relogio = ~relogio;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_checks++;
    if (obs === esp) n_pass++;
    else $display("FAIL %s: observed %h expected %h", tag, obs, esp);
  endtask

  task automatic tick();
    @(posedge relogio);
    #1;
  endtask

  // Counts edges until valida_out rises, bounded at 10.
  task automatic espera_valida(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!valida && n < 10);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    ram[0] = 16'hAAAA; ram[1] = 16'h5555; ram[2] = 16'hF0F0; ram[3] = 16'h0F0F;
    ram[4] = 16'hFF00; ram[5] = 16'h00FF; ram[6] = 16'hAA55; ram[7] = 16'h55AA;

    reinicia_n = 1'b1; inicia = 1'b0; salto = 1'b0; alvo = '0; aceita = 1'b0;
    #3 reinicia_n = 1'b0;
    #1;
    verifica("reset_pc",    pc, 0);
    verifica("reset_end",   endereco, 0);
    verifica("reset_instr", instrucao, 0);
    verifica("reset_valida", valida, 0);
    verifica("reset_ativo", ativo, 0);
    tick(); tick();
    #2 reinicia_n = 1'b1;

    // First fetch: two edges after inicia is seen in OCIOSO
    inicia = 1'b1; aceita = 1'b1;
    tick();
    verifica("start_ativo", ativo, 1);
    verifica("start_valida", valida, 0);
    espera_valida(n);
    verifica("latency_first", n, 2);
    verifica("word0_instr", instrucao, 16'hAAAA);
    verifica("word0_pc", pc, 0);

    // Sustained stream, including address wrap at PC 8
    for (int i = 1; i <= 8; i++) begin
      espera_valida(n);
      verifica($sformatf("period_%0d", i), n, 3);
      verifica($sformatf("word%0d_instr", i), instrucao, ram[i % 8]);
      verifica($sformatf("word%0d_pc", i), pc, i);
      verifica($sformatf("word%0d_end", i), endereco, i % 8);
    end

    // Consumer stalls for 5 cycles
    aceita = 1'b0;
    repeat (5) tick();
    verifica("stall_instr", instrucao, 16'hAAAA);
    verifica("stall_valida", valida, 1);
    verifica("stall_pc", pc, 8);

    // Jump on the same edge as acceptance
    aceita = 1'b1; salto = 1'b1; alvo = 16'h0005;
    tick();
    salto = 1'b0;
    verifica("jump_pc", pc, 16'h0005);
    verifica("jump_valida", valida, 0);
    espera_valida(n);
    verifica("jump_latency", n, 2);
    verifica("jump_instr", instrucao, 16'h00FF);
    verifica("jump_pc_word", pc, 16'h0005);

    // Stop request while holding a word: delivered, then idle
    inicia = 1'b0; aceita = 1'b0;
    tick();
    verifica("stop_hold_valida", valida, 1);
    verifica("stop_hold_ativo", ativo, 1);
    aceita = 1'b1;
    tick();
    verifica("stop_xfer_pc", pc, 6);
    verifica("stop_xfer_valida", valida, 0);
    tick();
    verifica("stop_ativo", ativo, 0);
    verifica("stop_instr", instrucao, 16'h00FF);

    // Jump while idle loads PC and stays idle
    salto = 1'b1; alvo = 16'h0003;
    tick();
    salto = 1'b0;
    verifica("idle_jump_pc", pc, 3);
    verifica("idle_jump_ativo", ativo, 0);

    // Reset during LE
    inicia = 1'b1;
    tick(); tick();
    verifica("pre_reset_end", endereco, 3);
    #2 reinicia_n = 1'b0;
    #1;
    verifica("midreset_pc", pc, 0);
    verifica("midreset_end", endereco, 0);
    verifica("midreset_instr", instrucao, 0);
    verifica("midreset_valida", valida, 0);
    verifica("midreset_ativo", ativo, 0);
    tick();
    #2 reinicia_n = 1'b1;
    espera_valida(n);
    verifica("restart_latency", n, 3);
    verifica("restart_instr", instrucao, 16'hAAAA);
    verifica("restart_pc", pc, 0);

    // PC wrap FFFF -> 0000
    salto = 1'b1; alvo = 16'hFFFF;
    tick();
    salto = 1'b0;
    espera_valida(n);
    verifica("top_instr", instrucao, 16'h55AA);
    verifica("top_end", endereco, 7);
    verifica("top_pc", pc, 16'hFFFF);
    espera_valida(n);
    verifica("wrap_period", n, 3);
    verifica("wrap_pc", pc, 16'h0000);
    verifica("wrap_instr", instrucao, 16'hAAAA);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/busca_instrucao.md
BUSCA_INSTRUCAO -- requirements
Module: busca_instrucao

Interface
REQ-001 Parameter LARGURA_DADO, default 16, SHALL set instruction/data word width.
REQ-002 Parameter LARGURA_END, default 3, SHALL set memory address width (8-word memory).
REQ-003 relogio_in  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reinicia_n_in  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 inicia_in  input  1  SHALL be a level request to fetch; low stops fetching at the next ENDERECA.
REQ-006 salto_in  input  1  SHALL request loading the PC from alvo_in.
REQ-007 alvo_in  input  16  SHALL be the jump target PC.
REQ-008 endereco_out  output  LARGURA_END  SHALL be the registered memory read address.
REQ-009 ram_dado_in  input  LARGURA_DADO  SHALL be the memory read data, combinational from endereco_out.
REQ-010 instrucao_out  output  LARGURA_DADO  SHALL be the registered fetched word.
REQ-011 valida_out  output  1  SHALL flag instrucao_out as valid for the consumer.
REQ-012 aceita_in  input  1  SHALL be the consumer's ready signal.
REQ-013 pc_out  output  16  SHALL be the current program counter.
REQ-014 ativo_out  output  1  SHALL be high in every state except OCIOSO.

Function
REQ-015 FSM states SHALL be OCIOSO, ENDERECA, LE, ENTREGA.
REQ-016 OCIOSO: inicia_in=1 -> ENDERECA; else stay.
REQ-017 ENDERECA: endereco_out SHALL be loaded with pc[LARGURA_END-1:0]; inicia_in=1 -> LE, inicia_in=0 -> OCIOSO.
REQ-018 LE: instrucao_out SHALL capture ram_dado_in, valida_out SHALL go 1; -> ENTREGA.
REQ-019 ENTREGA: hold instrucao_out and valida_out stable until aceita_in=1.
REQ-020 Transfer SHALL occur on an edge with valida_out=1 and aceita_in=1: PC increments by 1, valida_out drops, -> ENDERECA.
REQ-021 Latency: inicia_in sampled high in OCIOSO at edge k SHALL yield valida_out=1 after edge k+2.
REQ-022 Sustained throughput with aceita_in held high SHALL be one word per 3 cycles.
REQ-023 PC SHALL be 16 bits, wrap FFFF -> 0000; endereco_out uses low LARGURA_END bits, so address wraps 7 -> 0.
REQ-024 salto_in=1 in any state except OCIOSO SHALL load pc<=alvo_in, clear valida_out, go to ENDERECA; any pending word is discarded.
REQ-025 salto_in SHALL take priority over a simultaneous transfer (no increment, no transfer counted).
REQ-026 salto_in in OCIOSO SHALL load the PC and remain in OCIOSO.
REQ-027 inicia_in falling while in LE or ENTREGA SHALL NOT abort delivery; the FSM stops at the next ENDERECA.
REQ-028 aceita_in with valida_out=0 SHALL have no effect.

Reset
REQ-029 reinicia_n_in low SHALL immediately force state OCIOSO, pc_out=0, endereco_out=0, instrucao_out=0, valida_out=0, ativo_out=0.
REQ-030 Reset asserted mid-fetch SHALL discard the in-flight word; the first fetch after release restarts at PC 0.
REQ-031 Release of reset SHALL take effect from the first rising edge after deassertion.

Structure
REQ-032 Shared package SHALL hold state encodings and the width constants LARGURA_DADO, LARGURA_END, LARGURA_PC=16.
REQ-033 PC register (load, increment, async reset) SHALL be a sub-module named contador_programa.
REQ-034 FSM, address register and instruction register SHALL be in busca_instrucao.

Verification
REQ-035 RAM preloaded with AAAA, 5555, F0F0, 0F0F, FF00, 00FF, AA55, 55AA; inicia=1, aceita=1 -> words delivered in that order, each 3 cycles apart, pc_out 0..7.
REQ-036 Continue past PC 7 -> address wraps to 0, instrucao_out=AAAA, pc_out=8.
REQ-037 aceita=0 for 5 cycles in ENTREGA -> instrucao_out and valida_out stable, pc_out unchanged.
REQ-038 salto=1, alvo=0005 in the same cycle as aceita=1 -> next word 00FF, pc_out=0005, no extra increment.
REQ-039 reinicia_n low while in LE -> all outputs 0 immediately; after release, first word AAAA.
REQ-040 inicia dropped during ENTREGA -> current word still delivered on aceita, then FSM returns to OCIOSO with ativo_out=0.
